// File: rtl/fetch_unit_q_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory port and the
// valid/ready hand-off to decode. The master side is the fetch unit, the
// slave side is the surrounding core/memory environment.
interface fetch_unit_q_if #(
    parameter int PC_SIZE = 32,
    parameter int INSTR_W = 32
);
    logic               redirect;
    logic [PC_SIZE-1:0] redirect_pc;
    logic               imem_req;
    logic [PC_SIZE-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [PC_SIZE-1:0] out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        input  redirect, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_unit_q.sv
// Instruction-fetch stage with next-PC generation, redirect flush and a
// FQ_DEPTH-entry fetch queue between a 1-cycle-latency instruction memory
// and decode. Optional macro IF_PERF_CNT_EN adds the perf_fetched and
// perf_flushed event counters.
module fetch_unit_q #(
    parameter int                 PC_SIZE  = 32,
    parameter int                 INSTR_W  = 32,
    parameter int                 PC_STEP  = 1,
    parameter int                 FQ_DEPTH = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    fetch_unit_q_if.master            bus,
    output logic [$clog2(FQ_DEPTH):0] fq_count
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_flushed
`endif
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] OCC_LIMIT = (CW+1)'(FQ_DEPTH);

    logic [PC_SIZE-1:0] fetch_pc;
    logic [PC_SIZE-1:0] req_pc;
    logic               inflight;

    logic [PC_SIZE-1:0] pc_mem    [FQ_DEPTH];
    logic [INSTR_W-1:0] instr_mem [FQ_DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count;

    logic [CW:0]        occupancy;
    logic               issue;
    logic               enq;
    logic               deq;

    // Slots already reserved by queued entries plus the outstanding request
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

    // Issue only when a queue slot is guaranteed for the response
    assign issue = reset & ~bus.redirect & (occupancy < OCC_LIMIT);
    assign enq   = inflight & ~bus.redirect;
    assign deq   = (count != '0) & bus.out_ready;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = pc_mem[rd_ptr];
    assign bus.out_instr = instr_mem[rd_ptr];
    assign fq_count      = count;

    // Next-PC generation and in-flight tracking; redirect restarts at the target
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc <= fetch_pc + PC_SIZE'(PC_STEP);
            req_pc   <= fetch_pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue in one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: capture {req_pc, rdata} when a live response returns
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (enq) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Count decode transfers and entries/responses discarded by redirects
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (deq) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bus.redirect) begin
                perf_flushed <= perf_flushed + 32'(count) - 32'(deq) + 32'(inflight);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_q.sv
// Self-checking bench for fetch_unit_q: cycle-level vector table, hand-written
// redirect/reset sequences, a transfer scoreboard, and a narrow-PC instance
// that exercises PC wrap-around.
module tb_fetch_unit_q;
    logic clock = 1'b0;
    logic reset;
    logic reset_b;

    int n_checks = 0;
    int n_fail   = 0;

    // 10-unit clock period
    always #5 clock = ~clock;

    fetch_unit_q_if #(.PC_SIZE(32), .INSTR_W(32)) bus_a ();
    fetch_unit_q_if #(.PC_SIZE(8),  .INSTR_W(32)) bus_b ();

    logic [2:0] fq_count_a;
    logic [2:0] fq_count_b;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_a, perf_flushed_a;
    logic [31:0] perf_fetched_b, perf_flushed_b;
`endif

    fetch_unit_q #(
        .PC_SIZE(32), .INSTR_W(32), .PC_STEP(1), .FQ_DEPTH(4), .RESET_PC(32'h0)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus(bus_a.master),
        .fq_count(fq_count_a)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched_a),
        .perf_flushed(perf_flushed_a)
`endif
    );

    fetch_unit_q #(
        .PC_SIZE(8), .INSTR_W(32), .PC_STEP(1), .FQ_DEPTH(4), .RESET_PC(8'hFE)
    ) dut_b (
        .clock(clock),
        .reset(reset_b),
        .bus(bus_b.master),
        .fq_count(fq_count_b)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched_b),
        .perf_flushed(perf_flushed_b)
`endif
    );

    // Instruction memory models: rdata = 0x100 + addr, one cycle after the request
    always @(posedge clock) begin
        if (bus_a.imem_req) bus_a.imem_rdata <= 32'h100 + bus_a.imem_addr;
        if (bus_b.imem_req) bus_b.imem_rdata <= 32'h100 + {24'h0, bus_b.imem_addr};
    end

    typedef struct {
        logic        ready;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus_a.out_ready   = v.ready;
        bus_a.redirect    = v.redirect;
        bus_a.redirect_pc = v.redirect_pc;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench one unit after a rising edge with reset released: cycle 0
    task automatic reset_dut();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Scoreboard: sequential PCs from the model, restarted by redirect and reset
    initial begin
        exp_t e;
        model_pc = 32'h0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                exp_q.delete();
                model_pc = 32'h0;
            end else begin
                while (exp_q.size() < 2) begin
                    e.pc    = model_pc;
                    e.instr = 32'h100 + model_pc;
                    exp_q.push_back(e);
                    model_pc = model_pc + 32'd1;
                end
                if (bus_a.out_valid && bus_a.out_ready) begin
                    e = exp_q.pop_front();
                    check_output("sb_pc", bus_a.out_pc, e.pc);
                    check_output("sb_instr", bus_a.out_instr, e.instr);
                end
                if (bus_a.redirect) begin
                    exp_q.delete();
                    model_pc = bus_a.redirect_pc;
                end
            end
        end
    end

    initial begin
        vec_t       vecs[21];
        logic [7:0] exp_b [4];
        int         idx;

        bus_a.out_ready   = 1'b1;
        bus_a.redirect    = 1'b0;
        bus_a.redirect_pc = 32'h0;
        bus_b.out_ready   = 1'b1;
        bus_b.redirect    = 1'b0;
        bus_b.redirect_pc = 8'h0;
        reset   = 1'b0;
        reset_b = 1'b0;

        //        ready redir tgt     req  addr    valid cnt   pc
        vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 3'd0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h1,  1'b0, 3'd0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h2,  1'b1, 3'd1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h3,  1'b1, 3'd1, 32'h1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 3'd1, 32'h2};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h5,  1'b1, 3'd1, 32'h3};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h6,  1'b1, 3'd1, 32'h4};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h7,  1'b1, 3'd2, 32'h4};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 3'd3, 32'h4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 3'd4, 32'h4};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 3'd4, 32'h4};
        vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 3'd4, 32'h4};
        vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 3'd3, 32'h5};
        vecs[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h9,  1'b1, 3'd2, 32'h6};
        vecs[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hA,  1'b1, 3'd2, 32'h7};
        vecs[15] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hB,  1'b1, 3'd2, 32'h8};
        vecs[16] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 3'd2, 32'h9};
        vecs[17] = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  1'b1, 3'd2, 32'hA};
        vecs[18] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 3'd0, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h41, 1'b0, 3'd0, 32'h0};
        vecs[20] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h42, 1'b1, 3'd1, 32'h40};

        // Reset state, checked while reset is held
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("rst_req", bus_a.imem_req, 1'b0);
        check_output("rst_valid", bus_a.out_valid, 1'b0);
        check_output("rst_count", fq_count_a, 3'd0);
        check_output("rst_addr", bus_a.imem_addr, 32'h0);
        check_output("rst_pc", bus_a.out_pc, 32'h0);
        check_output("rst_instr", bus_a.out_instr, 32'h0);
`ifdef IF_PERF_CNT_EN
        check_output("rst_perf_fetched", perf_fetched_a, 32'h0);
        check_output("rst_perf_flushed", perf_flushed_a, 32'h0);
`endif

        // Streaming, back-pressure and a redirect alongside a transfer
        $display("[TB] vector table: stream, stall, redirect");
        reset_dut();
        for (int i = 0; i < 21; i++) begin
            if (i > 0) next_cycle();
            apply_stimulus(vecs[i]);
            @(negedge clock);
            check_output($sformatf("v%0d_req", i), bus_a.imem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) check_output($sformatf("v%0d_addr", i), bus_a.imem_addr, vecs[i].exp_addr);
            check_output($sformatf("v%0d_valid", i), bus_a.out_valid, vecs[i].exp_valid);
            check_output($sformatf("v%0d_count", i), fq_count_a, vecs[i].exp_count);
            if (vecs[i].exp_valid) begin
                check_output($sformatf("v%0d_pc", i), bus_a.out_pc, vecs[i].exp_pc);
                check_output($sformatf("v%0d_instr", i), bus_a.out_instr, 32'h100 + vecs[i].exp_pc);
            end
        end

        // Redirect with 3 queued entries and one response in flight, decode stalled
        $display("[TB] redirect with full reservation");
        bus_a.out_ready = 1'b0;
        bus_a.redirect  = 1'b0;
        reset_dut();
        repeat (4) next_cycle();
        bus_a.redirect    = 1'b1;
        bus_a.redirect_pc = 32'h40;
        @(negedge clock);
        check_output("r3_count_n", fq_count_a, 3'd3);
        check_output("r3_req_n", bus_a.imem_req, 1'b0);
        check_output("r3_held_pc", bus_a.out_pc, 32'h0);
        next_cycle();
        bus_a.redirect  = 1'b0;
        bus_a.out_ready = 1'b1;
        @(negedge clock);
        check_output("r3_count_n1", fq_count_a, 3'd0);
        check_output("r3_valid_n1", bus_a.out_valid, 1'b0);
        check_output("r3_req_n1", bus_a.imem_req, 1'b1);
        check_output("r3_addr_n1", bus_a.imem_addr, 32'h40);
`ifdef IF_PERF_CNT_EN
        check_output("r3_perf_flushed", perf_flushed_a, 32'd4);
        check_output("r3_perf_fetched", perf_fetched_a, 32'd0);
`endif
        next_cycle();
        @(negedge clock);
        check_output("r3_valid_n2", bus_a.out_valid, 1'b0);
        next_cycle();
        @(negedge clock);
        check_output("r3_valid_n3", bus_a.out_valid, 1'b1);
        check_output("r3_pc_n3", bus_a.out_pc, 32'h40);
        check_output("r3_instr_n3", bus_a.out_instr, 32'h140);

        // Redirect in the same cycle that pc 5 is transferred
        $display("[TB] redirect concurrent with transfer");
        reset_dut();
        repeat (7) next_cycle();
        bus_a.redirect    = 1'b1;
        bus_a.redirect_pc = 32'h40;
        @(negedge clock);
        check_output("r4_valid", bus_a.out_valid, 1'b1);
        check_output("r4_pc", bus_a.out_pc, 32'h5);
        next_cycle();
        bus_a.redirect = 1'b0;
        @(negedge clock);
        check_output("r4_valid_n1", bus_a.out_valid, 1'b0);
        repeat (2) next_cycle();
        @(negedge clock);
        check_output("r4_valid_n3", bus_a.out_valid, 1'b1);
        check_output("r4_pc_n3", bus_a.out_pc, 32'h40);
`ifdef IF_PERF_CNT_EN
        check_output("r4_perf_fetched", perf_fetched_a, 32'd6);
        check_output("r4_perf_flushed", perf_flushed_a, 32'd1);
`endif

        // Asynchronous reset between edges while streaming
        $display("[TB] asynchronous reset mid-stream");
        reset_dut();
        repeat (4) next_cycle();
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check_output("ar_valid", bus_a.out_valid, 1'b0);
        check_output("ar_req", bus_a.imem_req, 1'b0);
        check_output("ar_count", fq_count_a, 3'd0);
`ifdef IF_PERF_CNT_EN
        check_output("ar_perf_fetched", perf_fetched_a, 32'd0);
        check_output("ar_perf_flushed", perf_flushed_a, 32'd0);
`endif
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        check_output("ar_req_c0", bus_a.imem_req, 1'b1);
        check_output("ar_addr_c0", bus_a.imem_addr, 32'h0);
        repeat (2) next_cycle();
        @(negedge clock);
        check_output("ar_valid_c2", bus_a.out_valid, 1'b1);
        check_output("ar_pc_c2", bus_a.out_pc, 32'h0);
        check_output("ar_instr_c2", bus_a.out_instr, 32'h100);
        repeat (3) next_cycle();

        // Narrow PC wrap-around on the 8-bit instance
        $display("[TB] 8-bit PC wrap");
        exp_b[0] = 8'hFE;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h00;
        exp_b[3] = 8'h01;
        @(posedge clock);
        #1 reset_b = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clock);
            if (bus_b.out_valid) begin
                check_output($sformatf("wrap%0d_pc", idx), {24'h0, bus_b.out_pc}, {24'h0, exp_b[idx]});
                check_output($sformatf("wrap%0d_instr", idx), bus_b.out_instr, 32'h100 + {24'h0, exp_b[idx]});
                idx++;
            end
        end
        check_output("wrap_transfers", idx, 32'd4);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
